// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 frame-buffer loader: address/pixel widths,
// loader FSM states and the wrapping address step.
package hub75_pkg;

  localparam int FB_ADDR_W    = 15;
  localparam int PIXEL_WORD_W = 32;

  typedef logic [FB_ADDR_W-1:0]    fb_addr_t;
  typedef logic [PIXEL_WORD_W-1:0] pixel_word_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    LOAD      = 2'd2,
    FINISH    = 2'd3
  } fb_state_e;

  // Frame-buffer addresses wrap from the top word back to word 0.
  function automatic fb_addr_t fb_addr_next(input fb_addr_t addr);
    return addr + fb_addr_t'(1);
  endfunction

endpackage

// File: rtl/hub75_sync_fifo.sv
// Single-clock skid FIFO for pixel words; DEPTH must be a power of two.
// Read data is first-word fall-through, flush empties it in one cycle.
module hub75_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/hub75_fb_loader.sv
// Streams a counted run of pixel words into the HUB75 frame buffer at
// consecutive (wrapping) addresses, optionally starting on a frame edge.
module hub75_fb_loader
  import hub75_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_TO_FRAME = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    start,
  input  logic [FB_ADDR_W-1:0]    start_addr,
  input  logic [FB_ADDR_W-1:0]    word_count,
  input  logic                    abort,
  input  logic                    s_valid,
  input  logic [PIXEL_WORD_W-1:0] s_data,
  output logic                    s_ready,
  input  logic                    frame_sync,
  output logic                    wr_en,
  output logic [FB_ADDR_W-1:0]    wr_addr,
  output logic [PIXEL_WORD_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fb_state_e   state_q, state_d;
  fb_addr_t    addr_q, addr_d;
  fb_addr_t    cnt_q, cnt_d;
  fb_addr_t    acc_q, acc_d;
  fb_addr_t    wrn_q, wrn_d;
  logic        fs_prev_q;
  logic        wr_en_q, wr_en_d;
  fb_addr_t    wr_addr_q, wr_addr_d;
  pixel_word_t wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        busy_q;

  logic             fifo_flush_s, fifo_pop_s, accept_s;
  logic             fifo_full_s, fifo_empty_s;
  pixel_word_t      fifo_rdata_s;
  logic [CNT_W-1:0] fifo_count_s;

  // Ready depends only on registered state so the source sees no comb loop.
  assign s_ready  = (state_q == LOAD) && !fifo_full_s && (acc_q < cnt_q);
  assign accept_s = s_valid && s_ready;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign busy    = busy_q;

  hub75_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIXEL_WORD_W)
  ) u_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .flush_i (fifo_flush_s),
    .push_i  (accept_s),
    .wdata_i (s_data),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Next-state, counters, address generator and write-port staging.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    wrn_d        = wrn_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    fifo_pop_s   = 1'b0;
    fifo_flush_s = 1'b0;

    if (abort) begin
      state_d      = IDLE;
      fifo_flush_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d = start_addr;
            cnt_d  = word_count;
            acc_d  = '0;
            wrn_d  = '0;
            if (word_count == {FB_ADDR_W{1'b0}}) begin
              state_d = FINISH;
            end else if (SYNC_TO_FRAME != 0) begin
              state_d = WAIT_SYNC;
            end else begin
              state_d = LOAD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_SYNC: begin
          if (frame_sync && !fs_prev_q) begin
            state_d = LOAD;
          end else begin
            state_d = WAIT_SYNC;
          end
        end
        LOAD: begin
          if (accept_s) begin
            acc_d = acc_q + fb_addr_t'(1);
          end else begin
            acc_d = acc_q;
          end
          if (!fifo_empty_s) begin
            fifo_pop_s = 1'b1;
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = fifo_rdata_s;
            addr_d     = fb_addr_next(addr_q);
            wrn_d      = wrn_q + fb_addr_t'(1);
          end else begin
            fifo_pop_s = 1'b0;
          end
          // Never leave LOAD while accepted words are still queued.
          if ((wrn_q == cnt_q) && (fifo_count_s == {CNT_W{1'b0}})) begin
            state_d = FINISH;
          end else begin
            state_d = LOAD;
          end
        end
        FINISH: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      wrn_q     <= '0;
      fs_prev_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      wrn_q     <= wrn_d;
      fs_prev_q <= frame_sync;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_hub75_fb_loader.sv
// Randomised scoreboard bench for hub75_fb_loader: dut0 loads immediately,
// dut1 waits for a frame_sync rising edge.
module tb_hub75_fb_loader;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        presetn, abort, s_valid, frame_sync;
  logic [31:0] s_data;
  logic [14:0] start_addr, word_count;
  logic [1:0]  start_v, s_ready_v, wr_en_v, busy_v, done_v;
  logic [14:0] wr_addr_v [2];
  logic [31:0] wr_data_v [2];

  hub75_fb_loader #(.FIFO_DEPTH(4), .SYNC_TO_FRAME(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .start(start_v[0]), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_v[0]), .frame_sync(frame_sync), .wr_en(wr_en_v[0]),
    .wr_addr(wr_addr_v[0]), .wr_data(wr_data_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  hub75_fb_loader #(.FIFO_DEPTH(4), .SYNC_TO_FRAME(1)) dut1 (
    .pclk(pclk), .presetn(presetn), .start(start_v[1]), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_v[1]), .frame_sync(frame_sync), .wr_en(wr_en_v[1]),
    .wr_addr(wr_addr_v[1]), .wr_data(wr_data_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  // Reference model: per-DUT mode, expected write queue and done deadline.
  localparam int QD = 64;
  localparam int M_IDLE = 0, M_WAIT = 1, M_LOAD = 2, M_FIN = 3;
  int          m_st [2];
  int          m_base [2], m_cnt [2], m_acc [2], m_wr [2], m_due [2];
  int          q_due [2][QD];
  logic [14:0] q_addr [2][QD];
  logic [31:0] q_data [2][QD];
  int          q_hd [2], q_tl [2];
  logic        m_fsp;
  int          cyc, vectors, miscompares, tmo_cnt, tmo_seen;
  int          wr_seen [2];
  bit          exp_wr, exp_done;

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, got, exp);
    end
  endtask

  always @(negedge pclk) begin
    cyc++;
    if (tmo_cnt != tmo_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout cyc=%0d got=no done expected=done within budget", cyc);
      tmo_seen = tmo_cnt;
    end
    for (int k = 0; k < 2; k++) begin
      if (!presetn) begin
        chk("reset_outputs", k,
            {wr_en_v[k], done_v[k], busy_v[k], s_ready_v[k], wr_addr_v[k], wr_data_v[k]}, 64'd0);
        m_st[k] = M_IDLE;
        q_hd[k] = q_tl[k];
        m_due[k] = -1;
      end else begin
        exp_wr = (q_hd[k] != q_tl[k]) && (q_due[k][q_hd[k] % QD] == cyc);
        chk("wr_en", k, 64'(wr_en_v[k]), 64'(exp_wr));
        if (exp_wr) begin
          if (wr_en_v[k]) begin
            chk("wr_addr", k, 64'(wr_addr_v[k]), 64'(q_addr[k][q_hd[k] % QD]));
            chk("wr_data", k, 64'(wr_data_v[k]), 64'(q_data[k][q_hd[k] % QD]));
          end
          q_hd[k]++;
          m_wr[k]++;
          if (m_wr[k] == m_cnt[k]) m_due[k] = cyc + 2;
        end
        if (wr_en_v[k]) wr_seen[k]++;

        exp_done = (cyc == m_due[k]);
        if (exp_done) begin
          m_st[k] = M_IDLE;
          m_due[k] = -1;
        end
        if (done_v[k] || exp_done) chk("done", k, 64'(done_v[k]), 64'(exp_done));
        chk("busy", k, 64'(busy_v[k]), 64'(m_st[k] != M_IDLE));
        chk("s_ready", k, 64'(s_ready_v[k]), 64'((m_st[k] == M_LOAD) && (m_acc[k] < m_cnt[k])));

        if (abort) begin
          m_st[k] = M_IDLE;
          q_hd[k] = q_tl[k];
          m_due[k] = -1;
        end else begin
          case (m_st[k])
            M_IDLE: if (start_v[k]) begin
              m_base[k] = int'(start_addr);
              m_cnt[k]  = int'(word_count);
              m_acc[k]  = 0;
              m_wr[k]   = 0;
              if (word_count == 15'd0) begin
                m_st[k]  = M_FIN;
                m_due[k] = cyc + 2;
              end else begin
                m_st[k] = (k == 1) ? M_WAIT : M_LOAD;
              end
            end
            M_WAIT: if (frame_sync && !m_fsp) m_st[k] = M_LOAD;
            M_LOAD: if (s_valid && s_ready_v[k]) begin
              q_due[k][q_tl[k] % QD]  = cyc + 2;
              q_addr[k][q_tl[k] % QD] = 15'((m_base[k] + m_acc[k]) % 32768);
              q_data[k][q_tl[k] % QD] = s_data;
              q_tl[k]++;
              m_acc[k]++;
            end
            default: ;
          endcase
        end
      end
    end
    m_fsp = presetn ? frame_sync : 1'b0;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic run_load(input int k, input logic [14:0] addr, input logic [14:0] wc,
                          input int vmode, input bit directed, input int extra_start_at,
                          input int fs_at, input int abort_after, input int rst_after);
    int          fed;
    bit          hs, dn, fin;
    logic [31:0] cur;
    fed = 0;
    fin = 1'b0;
    cur = directed ? 32'h0000_00A0 : $urandom;
    start_addr = addr;
    word_count = wc;
    start_v[k] = 1'b1;
    tick();
    start_v[k] = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = (c % 2 == 0);
        default: s_valid = ($urandom_range(0, 99) < 60);
      endcase
      s_valid = s_valid && ((fed < int'(wc)) || (wc == 15'd0));
      s_data = cur;
      if (c == extra_start_at && fed < int'(wc)) begin
        start_addr = 15'($urandom);
        word_count = 15'($urandom_range(1, 9));
        start_v[k] = 1'b1;
      end else begin
        start_v[k] = 1'b0;
      end
      frame_sync = (fs_at < 0) ? 1'($urandom_range(0, 1)) : (c == fs_at);
      @(negedge pclk);
      hs = s_valid && s_ready_v[k];
      dn = done_v[k];
      tick();
      if (hs) begin
        fed++;
        cur = directed ? (32'h0000_00A0 + 32'(fed)) : $urandom;
      end
      if (dn) begin
        fin = 1'b1;
      end else if (abort_after > 0 && fed == abort_after) begin
        abort = 1'b1;
        s_valid = 1'b1;
        s_data = cur;
        start_v[k] = 1'b0;
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        fin = 1'b1;
      end else if (rst_after > 0 && fed == rst_after) begin
        presetn = 1'b0;
        s_valid = 1'b0;
        start_v[k] = 1'b0;
        @(negedge pclk);
        #2;
        presetn = 1'b1;
        tick();
        fin = 1'b1;
      end
    end
    if (!fin) tmo_cnt++;
    s_valid = 1'b0;
    start_v[k] = 1'b0;
    frame_sync = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    presetn = 1'b0; start_v = 2'b00; abort = 1'b0; s_valid = 1'b0; s_data = 32'd0;
    frame_sync = 1'b0; start_addr = 15'd0; word_count = 15'd0; tmo_cnt = 0;
    repeat (3) @(posedge pclk);
    #1;
    presetn = 1'b1;
    tick();
    run_load(0, 15'h0010, 15'd4, 0, 1'b1, -1, -1, 0, 0);
    run_load(0, 15'h7FFE, 15'd3, 0, 1'b0, -1, -1, 0, 0);
    run_load(0, 15'h0100, 15'd8, 1, 1'b0, 5, -1, 0, 0);
    run_load(1, 15'h0200, 15'd5, 0, 1'b0, -1, 10, 0, 0);
    run_load(0, 15'h0300, 15'd0, 0, 1'b0, -1, -1, 0, 0);
    run_load(0, 15'h0400, 15'd8, 0, 1'b0, -1, -1, 3, 0);
    run_load(0, 15'h0500, 15'd8, 0, 1'b0, -1, -1, 0, 3);
    for (int i = 0; i < 9; i++) begin
      run_load((i % 3 == 2) ? 1 : 0, 15'($urandom), 15'($urandom_range(1, 12)),
               $urandom_range(0, 2), 1'b0, $urandom_range(2, 10),
               (i % 3 == 2) ? $urandom_range(2, 12) : -1, 0, 0);
    end
    run_load(0, 15'h7FF8, 15'd12, 2, 1'b0, -1, -1, 0, 0);
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
